// File: rtl/slot_locator_if.sv
// -----------------------------------------------------------------------------
// slot_locator_if
// Bundles the two request/response paths of the slot locator:
//   place path : place_valid, place_slot  -> place_done, place_ok
//   query path : query_valid, query_x, query_y, query_grab -> query_ready,
//                result_valid, result_hit, result_slot, result_x, result_y
// master : the requester side (spawner / hook logic)
// slave  : the slot locator itself
// -----------------------------------------------------------------------------
interface slot_locator_if;
  logic       place_valid;
  logic [5:0] place_slot;
  logic       place_done;
  logic       place_ok;

  logic       query_valid;
  logic       query_ready;
  logic [8:0] query_x;
  logic [7:0] query_y;
  logic       query_grab;

  logic       result_valid;
  logic       result_hit;
  logic [5:0] result_slot;
  logic [8:0] result_x;
  logic [7:0] result_y;

  modport master (
    output place_valid, place_slot, query_valid, query_x, query_y, query_grab,
    input  place_done, place_ok, query_ready,
           result_valid, result_hit, result_slot, result_x, result_y
  );

  modport slave (
    input  place_valid, place_slot, query_valid, query_x, query_y, query_grab,
    output place_done, place_ok, query_ready,
           result_valid, result_hit, result_slot, result_x, result_y
  );
endinterface

// File: rtl/slot_locator.sv
// -----------------------------------------------------------------------------
// slot_locator
// Coordinate-to-slot decoder and occupancy tracker for the 8x8 gold playfield.
// Slot s = {row, col}; cell origin x = X0 + XSTEP*col, y = Y0 + YSTEP*row;
// the object box inside a cell is OBJ_W x OBJ_H pixels.
//
// Ports:
//   clk            system clock, all logic on posedge
//   resetn         synchronous reset, active HIGH despite the name
//   clear_all      1-cycle pulse, frees all 64 slots
//   bus            slot_locator_if.slave (place path + query/result path)
//   occupied_count number of occupied slots (0 unless counter is enabled)
//
// Optional feature macro: SLOT_LOCATOR_COUNT_EN
//   defined   -> occupied_count is a registered popcount-tracking counter
//   undefined -> occupied_count is tied to 0
//
// Query timing: accept edge T, 8 DIVIDE cycles, 1 CHECK cycle, RESP cycle;
// result_valid is high in the cycle following edge T+10.
// -----------------------------------------------------------------------------
module slot_locator #(
  parameter int X0    = 2,
  parameter int Y0    = 50,
  parameter int XSTEP = 42,
  parameter int YSTEP = 24,
  parameter int OBJ_W = 40,
  parameter int OBJ_H = 20
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear_all,
  slot_locator_if.slave      bus,
  output logic [6:0]         occupied_count
);

  localparam logic [9:0] X0_W    = 10'(X0);
  localparam logic [9:0] Y0_W    = 10'(Y0);
  localparam logic [9:0] XSTEP_W = 10'(XSTEP);
  localparam logic [9:0] YSTEP_W = 10'(YSTEP);
  localparam logic [9:0] OBJW_W  = 10'(OBJ_W);
  localparam logic [9:0] OBJH_W  = 10'(OBJ_H);
  localparam logic [9:0] X_END   = 10'(X0 + 8 * XSTEP);
  localparam logic [9:0] Y_END   = 10'(Y0 + 8 * YSTEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    CHECK  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        grab_q, grab_d;
  logic [9:0]  x_rem_q, x_rem_d;
  logic [9:0]  y_rem_q, y_rem_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic        hit_q, hit_d;
  logic [63:0] occ_q, occ_d;

  logic        place_done_q, place_done_d;
  logic        place_ok_q, place_ok_d;
  logic        result_valid_q, result_valid_d;
  logic        result_hit_q, result_hit_d;
  logic [5:0]  result_slot_q, result_slot_d;
  logic [8:0]  result_x_q, result_x_d;
  logic [7:0]  result_y_q, result_y_d;

  logic [5:0]  slot;
  logic        in_range;
  logic        place_win;
  logic        grab_clr;

  assign slot = {row_q, col_q};

  // Range test on the raw latched coordinates, not on the remainders, so
  // wrapped remainders from x < X0 or y < Y0 can never look in range.
  assign in_range = ({1'b0, x_q} >= X0_W) && ({1'b0, x_q} < X_END) &&
                    ({2'b00, y_q} >= Y0_W) && ({2'b00, y_q} < Y_END);

  // A place is refused while clear_all wipes the map.
  assign place_win = bus.place_valid && !clear_all && !occ_q[bus.place_slot];

  // Only clear a bit that is still set: if the slot was freed between CHECK
  // and RESP, a concurrent place of that slot must win and the counter must
  // not double-decrement.
  assign grab_clr = (state_q == RESP) && grab_q && hit_q && occ_q[slot];

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    x_d            = x_q;
    y_d            = y_q;
    grab_d         = grab_q;
    x_rem_d        = x_rem_q;
    y_rem_d        = y_rem_q;
    col_d          = col_q;
    row_d          = row_q;
    hit_d          = hit_q;
    result_valid_d = 1'b0;
    result_hit_d   = result_hit_q;
    result_slot_d  = result_slot_q;
    result_x_d     = result_x_q;
    result_y_d     = result_y_q;

    unique case (state_q)
      IDLE: begin
        if (bus.query_valid) begin
          x_d     = bus.query_x;
          y_d     = bus.query_y;
          grab_d  = bus.query_grab;
          x_rem_d = {1'b0, bus.query_x} - X0_W;
          y_rem_d = {2'b00, bus.query_y} - Y0_W;
          col_d   = 3'd0;
          row_d   = 3'd0;
          step_d  = 3'd0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        // Restoring division by repeated subtraction, one step per cycle
        // per axis; 8 steps cover the largest in-range quotient of 7.
        if (x_rem_q >= XSTEP_W) begin
          x_rem_d = x_rem_q - XSTEP_W;
          col_d   = col_q + 3'd1;
        end
        if (y_rem_q >= YSTEP_W) begin
          y_rem_d = y_rem_q - YSTEP_W;
          row_d   = row_q + 3'd1;
        end
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        // A clear_all in this very cycle already counts as an empty map.
        hit_d   = in_range && (x_rem_q < OBJW_W) && (y_rem_q < OBJH_W) &&
                  occ_q[slot] && !clear_all;
        state_d = RESP;
      end
      RESP: begin
        result_valid_d = 1'b1;
        result_hit_d   = hit_q;
        if (in_range) begin
          result_slot_d = slot;
          // Origin = tip minus remainder; avoids a constant multiplier.
          result_x_d    = x_q - x_rem_q[8:0];
          result_y_d    = y_q - y_rem_q[7:0];
        end else begin
          result_slot_d = 6'd0;
          result_x_d    = 9'd0;
          result_y_d    = 8'd0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d        = occ_q;
    place_done_d = bus.place_valid;
    place_ok_d   = place_ok_q;
    if (bus.place_valid) begin
      place_ok_d = place_win;
    end
    if (clear_all) begin
      occ_d = 64'd0;
    end else begin
      if (place_win) begin
        occ_d[bus.place_slot] = 1'b1;
      end
      if (grab_clr) begin
        occ_d[slot] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q        <= IDLE;
      step_q         <= 3'd0;
      x_q            <= 9'd0;
      y_q            <= 8'd0;
      grab_q         <= 1'b0;
      x_rem_q        <= 10'd0;
      y_rem_q        <= 10'd0;
      col_q          <= 3'd0;
      row_q          <= 3'd0;
      hit_q          <= 1'b0;
      occ_q          <= 64'd0;
      place_done_q   <= 1'b0;
      place_ok_q     <= 1'b0;
      result_valid_q <= 1'b0;
      result_hit_q   <= 1'b0;
      result_slot_q  <= 6'd0;
      result_x_q     <= 9'd0;
      result_y_q     <= 8'd0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      x_q            <= x_d;
      y_q            <= y_d;
      grab_q         <= grab_d;
      x_rem_q        <= x_rem_d;
      y_rem_q        <= y_rem_d;
      col_q          <= col_d;
      row_q          <= row_d;
      hit_q          <= hit_d;
      occ_q          <= occ_d;
      place_done_q   <= place_done_d;
      place_ok_q     <= place_ok_d;
      result_valid_q <= result_valid_d;
      result_hit_q   <= result_hit_d;
      result_slot_q  <= result_slot_d;
      result_x_q     <= result_x_d;
      result_y_q     <= result_y_d;
    end
  end

  assign bus.query_ready  = (state_q == IDLE);
  assign bus.place_done   = place_done_q;
  assign bus.place_ok     = place_ok_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_hit   = result_hit_q;
  assign bus.result_slot  = result_slot_q;
  assign bus.result_x     = result_x_q;
  assign bus.result_y     = result_y_q;

`ifdef SLOT_LOCATOR_COUNT_EN
  logic [6:0] count_q, count_d;

  // place_win and grab_clr can never target the same set bit, so the
  // counter tracks popcount(occ) exactly; both on one edge nets to zero.
  always_comb begin
    count_d = count_q;
    if (clear_all) begin
      count_d = 7'd0;
    end else begin
      count_d = count_q + {6'd0, place_win} - {6'd0, grab_clr};
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      count_q <= 7'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign occupied_count = count_q;
`else
  assign occupied_count = 7'd0;
`endif

endmodule

// File: tb/tb_slot_locator.sv
// -----------------------------------------------------------------------------
// tb_slot_locator
// Directed bench for slot_locator: placement, coordinate decode, gaps,
// out-of-range, grab, place/grab collision, clear_all, reset mid-query and
// the optional occupancy counter (expected 0 when the counter is disabled).
// -----------------------------------------------------------------------------
module tb_slot_locator;

`ifdef SLOT_LOCATOR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       resetn;
  logic       clear_all;
  logic [6:0] occupied_count;
  int         n_cmp;
  int         n_bad;
  logic       early;

  slot_locator_if bus();

  slot_locator dut (
    .clk            (clk),
    .resetn         (resetn),
    .clear_all      (clear_all),
    .bus            (bus),
    .occupied_count (occupied_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int n);
    chk(tag, {25'd0, occupied_count}, CNT_EN ? n : 0);
  endtask

  task automatic do_place(input string tag, input logic [5:0] s, input logic exp_ok);
    bus.place_valid = 1'b1;
    bus.place_slot  = s;
    tick();
    bus.place_valid = 1'b0;
    chk({tag, ".done"}, bus.place_done, 1'b1);
    chk({tag, ".ok"}, bus.place_ok, exp_ok);
    $display("place %s slot=%0d ok=%0d", tag, s, bus.place_ok);
  endtask

  // clr_at: pulse clear_all on edge T+clr_at (0 = none).
  // resp_place: place pslot on the RESP edge T+10, expecting place_ok = 0.
  task automatic do_query(input string tag, input logic [8:0] qx, input logic [7:0] qy,
                          input logic grab, input logic e_hit, input logic [5:0] e_slot,
                          input logic [8:0] e_x, input logic [7:0] e_y,
                          input int clr_at, input logic resp_place, input logic [5:0] pslot);
    int n;
    n = 0;
    while (!bus.query_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".ready"}, bus.query_ready, 1'b1);
    bus.query_valid = 1'b1;
    bus.query_x     = qx;
    bus.query_y     = qy;
    bus.query_grab  = grab;
    tick();
    bus.query_valid = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == clr_at) clear_all = 1'b1;
      tick();
      clear_all = 1'b0;
      early = early | bus.result_valid;
    end
    if (resp_place) begin
      bus.place_valid = 1'b1;
      bus.place_slot  = pslot;
    end
    tick();
    bus.place_valid = 1'b0;
    chk({tag, ".early"}, early, 1'b0);
    chk({tag, ".valid"}, bus.result_valid, 1'b1);
    chk({tag, ".hit"}, bus.result_hit, e_hit);
    chk({tag, ".slot"}, bus.result_slot, e_slot);
    chk({tag, ".x"}, bus.result_x, e_x);
    chk({tag, ".y"}, bus.result_y, e_y);
    if (resp_place) begin
      chk({tag, ".pdone"}, bus.place_done, 1'b1);
      chk({tag, ".pok"}, bus.place_ok, 1'b0);
    end
    $display("query %s (%0d,%0d) grab=%0d -> hit=%0d slot=%0d origin=(%0d,%0d)",
             tag, qx, qy, grab, bus.result_hit, bus.result_slot, bus.result_x, bus.result_y);
    tick();
    chk({tag, ".pulse"}, bus.result_valid, 1'b0);
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    resetn          = 1'b1;
    clear_all       = 1'b0;
    bus.place_valid = 1'b0;
    bus.place_slot  = 6'd0;
    bus.query_valid = 1'b0;
    bus.query_x     = 9'd0;
    bus.query_y     = 8'd0;
    bus.query_grab  = 1'b0;
    repeat (3) tick();
    resetn = 1'b0;
    tick();

    chk("rst.ready", bus.query_ready, 1'b1);
    chk("rst.rv", bus.result_valid, 1'b0);
    chk("rst.done", bus.place_done, 1'b0);
    chk("rst.ok", bus.place_ok, 1'b0);
    chk("rst.hit", bus.result_hit, 1'b0);
    chk_cnt("rst.cnt", 0);

    // Basic decode of slot 9 (col 1, row 1), origin (44,74)
    do_place("p9", 6'd9, 1'b1);
    do_query("q9", 9'd49, 8'd77, 1'b0, 1'b1, 6'd9, 9'd44, 8'd74, 0, 1'b0, 6'd0);
    do_query("xrem39", 9'd83, 8'd77, 1'b0, 1'b1, 6'd9, 9'd44, 8'd74, 0, 1'b0, 6'd0);
    do_query("xgap", 9'd84, 8'd77, 1'b0, 1'b0, 6'd9, 9'd44, 8'd74, 0, 1'b0, 6'd0);
    do_query("ygap", 9'd49, 8'd241, 1'b0, 1'b0, 6'd57, 9'd44, 8'd218, 0, 1'b0, 6'd0);

    // Out of range on each boundary
    do_query("xlow", 9'd1, 8'd100, 1'b0, 1'b0, 6'd0, 9'd0, 8'd0, 0, 1'b0, 6'd0);
    do_query("xhigh", 9'd338, 8'd100, 1'b0, 1'b0, 6'd0, 9'd0, 8'd0, 0, 1'b0, 6'd0);
    do_query("yhigh", 9'd100, 8'd242, 1'b0, 1'b0, 6'd0, 9'd0, 8'd0, 0, 1'b0, 6'd0);

    // Grab slot 63, origin (296,218)
    do_place("p63", 6'd63, 1'b1);
    do_query("grab63", 9'd300, 8'd220, 1'b1, 1'b1, 6'd63, 9'd296, 8'd218, 0, 1'b0, 6'd0);
    do_query("regrab63", 9'd300, 8'd220, 1'b1, 1'b0, 6'd63, 9'd296, 8'd218, 0, 1'b0, 6'd0);
    do_place("p63b", 6'd63, 1'b1);

    // Double place, then place colliding with a grab of slot 5, origin (212,50)
    do_place("p5", 6'd5, 1'b1);
    do_place("p5dup", 6'd5, 1'b0);
    do_query("grab5", 9'd215, 8'd55, 1'b1, 1'b1, 6'd5, 9'd212, 8'd50, 0, 1'b1, 6'd5);
    do_place("p5free", 6'd5, 1'b1);
    chk_cnt("cnt3", 3);

    // clear_all during DIVIDE: the query sees an empty map
    do_query("clrq", 9'd49, 8'd77, 1'b0, 1'b0, 6'd9, 9'd44, 8'd74, 3, 1'b0, 6'd0);
    chk_cnt("cnt.clr", 0);

    // Counter path; slot 1 origin (44,50)
    do_place("p0", 6'd0, 1'b1);
    do_place("p1", 6'd1, 1'b1);
    do_place("p2", 6'd2, 1'b1);
    chk_cnt("cnt.p012", 3);
    do_query("grab1", 9'd45, 8'd51, 1'b1, 1'b1, 6'd1, 9'd44, 8'd50, 0, 1'b0, 6'd0);
    chk_cnt("cnt.grab1", 2);
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    chk_cnt("cnt.clr2", 0);
    $display("clear_all count=%0d", occupied_count);

    // Reset mid-query
    do_place("p3", 6'd3, 1'b1);
    bus.query_valid = 1'b1;
    bus.query_x     = 9'd130;
    bus.query_y     = 8'd52;
    bus.query_grab  = 1'b0;
    tick();
    bus.query_valid = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      early = early | bus.result_valid;
    end
    chk("mid.norv", early, 1'b0);
    chk("mid.ready", bus.query_ready, 1'b1);
    chk("mid.done", bus.place_done, 1'b0);
    chk("mid.ok", bus.place_ok, 1'b0);
    chk("mid.hit", bus.result_hit, 1'b0);
    chk("mid.slot", bus.result_slot, 6'd0);
    chk("mid.x", bus.result_x, 9'd0);
    chk("mid.y", bus.result_y, 8'd0);
    chk_cnt("mid.cnt", 0);
    $display("reset mid-query rv_seen=%0d", early);
    do_query("post3", 9'd130, 8'd52, 1'b0, 1'b0, 6'd3, 9'd128, 8'd50, 0, 1'b0, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slot_locator.md
Name: slot_locator

Overview:
- Coordinate-to-slot decoder and occupancy tracker for the gold playfield: the inverse of the random spawn-position generator.
- The playfield is an 8x8 grid, 64 slots. Slot s has column c = s[2:0] and row r = s[5:3].
- Cell origin is x = 2 + 42*c, y = 50 + 24*r. The object box inside each cell is 40 x 20 px.
- The spawner claims slots through a place port. The hook logic submits the hook-tip pixel through a query port and gets back hit/miss, the slot index and the cell origin. A query can optionally grab (free) the slot.

Parameters:
- X0, 2, x of column 0 origin
- Y0, 50, y of row 0 origin
- XSTEP, 42, column pitch in px
- YSTEP, 24, row pitch in px
- OBJ_W, 40, object box width in px
- OBJ_H, 20, object box height in px

Ports:
- clk  in  1  system clock, all logic on posedge
- resetn  in  1  synchronous, active-high reset
- clear_all  in  1  1-cycle pulse, frees all 64 slots
- place_valid  in  1  claim request
- place_slot  in  6  slot index to claim
- place_done  out  1  1-cycle pulse, one cycle after the request
- place_ok  out  1  1 = claimed, 0 = slot was already occupied
- query_valid  in  1  coordinate lookup request
- query_ready  out  1  high only in IDLE
- query_x  in  9  hook-tip x
- query_y  in  8  hook-tip y
- query_grab  in  1  free the slot on hit
- result_valid  out  1  1-cycle pulse
- result_hit  out  1  tip inside an occupied object box
- result_slot  out  6  decoded slot index
- result_x  out  9  cell origin x
- result_y  out  8  cell origin y
- occupied_count  out  7  number of occupied slots, 0..64

Behaviour:
Reset:
- occ[63:0] = 0, state = IDLE.
- All outputs 0, except query_ready = 1.

Query FSM, states IDLE -> DIVIDE -> CHECK -> RESP -> IDLE:
- The query is accepted on the edge where query_valid & query_ready. Inputs x, y and grab are latched at that edge.
- DIVIDE lasts exactly 8 cycles. Remainders start at x - X0 and y - Y0. Each cycle, XSTEP is subtracted from the x remainder when it is >= XSTEP, incrementing col; YSTEP is handled the same way for row. Divider datapaths are 10 bits wide, no hardware divider.
- Out of range when x < 2, x >= 338, y < 50 or y >= 242. Comparisons are unsigned, done on the raw latched inputs.
- CHECK: hit = in-range & x_rem < OBJ_W & y_rem < OBJ_H & occ[{row, col}].
- RESP: result_valid = 1 for exactly one cycle. The accept edge is T; result_valid is high in the cycle after edge T+10.
- Result registers hold their values until the next RESP.
- Out of range: result_hit = 0, result_slot = 0, result_x = 0, result_y = 0.
- In range but outside the box, e.g. in the 2 px x-gap or 4 px y-gap: result_hit = 0, and slot/origin still report the decoded cell.
- Hit with grab = 1: occ bit is cleared on the RESP edge.
- query_ready returns high the cycle after RESP. Back-to-back throughput is 1 query per 11 cycles.

Place path, independent of the FSM, usable in any state:
- place_valid at edge E: place_done = 1 after E, one cycle.
- place_ok = !occ[place_slot] sampled before edge E.
- If ok, occ bit is set at E.

Simultaneous events, priority order:
- resetn is highest: it clears occ and returns the FSM to IDLE.
- clear_all next: occ = 0. A concurrent place is reported place_ok = 0 and not applied. An in-flight query continues, and its CHECK uses the cleared map.
- Place and grab of the same slot on the same edge: place sees the pre-edge occ (occupied, so place_ok = 0). The grab clears the bit, so the final state is free.
- Reset mid-query: result_valid never fires for that query.

Optional Feature:
- SLOT_LOCATOR_COUNT_EN defined: occupied_count is a registered counter.
  - +1 on each successful place.
  - -1 on each grab hit.
  - Net 0 when both happen on the same edge.
  - Forced to 0 on clear_all or reset.
  - Always equals popcount(occ).
- Not defined: occupied_count is tied to 0 and no counter logic is built.

Test Plan:
- Place slot 9 -> place_ok = 1. Query (49,77) -> hit = 1, slot = 9, origin (44,74), result_valid exactly 11 cycles after accept.
- Slot 9 occupied. Query (83,77) -> hit = 1, x_rem = 39. Query (84,77) -> hit = 0, slot = 9 (x-gap). Query (49,241) -> hit = 0, slot = 57 (y-gap).
- Query (1,100), then (338,100), then (100,242) -> each gives hit = 0, slot = 0, origin (0,0).
- Place slot 63, query (300,220) with grab = 1 -> hit = 1, slot = 63. Repeat the same query -> hit = 0. Place 63 again -> place_ok = 1.
- Place slot 5 twice -> second place_ok = 0. Then place slot 5 on the same edge as a grab-hit on slot 5 -> place_ok = 0, slot ends free. clear_all during a query -> that query reports hit = 0.
- With SLOT_LOCATOR_COUNT_EN: place 0, 1 and 2 -> count = 3. Grab-hit 1 -> count = 2. clear_all -> count = 0. Reset asserted mid-query -> no result_valid, all outputs back to reset values.
